pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core (inst_f -> id -> alu -> mem -> wb). It owns the run/drain lifecycle (valid starts, opr_finished stops) and drives the IF-stage hazard stall. It detects load-use hazards and inserts ID/EX bubbles, flushes IF/ID on a taken branch, and produces EX operand forwarding selects from the EX/MEM and MEM/WB destination registers. Instantiated in main next to the stage modules.

Parameters:
ADDR_LINE_REG, 5, register-file address width
FLUSH_CYCLES, 2, cycles if_id_flush is held after a taken branch (1..7)
DRAIN_CYCLES, 4, cycles to retire in-flight instructions after stop (1..15)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
valid  in  1  start request, sampled in IDLE
opr_finished  in  1  stop request, sampled in RUN/STALL/FLUSH
id_rs_addr  in  ADDR_LINE_REG  rs of instruction in ID
id_rt_addr  in  ADDR_LINE_REG  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_rd_addr  in  ADDR_LINE_REG  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
memst_rd_addr  in  ADDR_LINE_REG  destination in EX/MEM
memst_reg_write  in  1  EX/MEM writes the register file
wb_rd_addr  in  ADDR_LINE_REG  destination in MEM/WB
wb_reg_write  in  1  MEM/WB writes the register file
branch_taken  in  1  taken branch resolved in EX this cycle
hazard  out  1  freeze PC and IF/ID register
id_ex_bubble  out  1  load NOP into ID/EX
if_id_flush  out  1  clear IF/ID to NOP
fwd_a  out  2  rs operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  rt operand select, same encoding
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at end of drain
stall_count  out  16  load-use stall cycles since last start, saturating

Behaviour:
- States: IDLE, RUN, STALL, FLUSH, DRAIN, DONE. The state register updates on the clk rising edge. reset has priority over all other inputs.
- Reset (any state, mid-operation included): state=IDLE, flush/drain counters=0, pend_stop=0, stall_count=0.
- Outputs while in IDLE after reset: hazard=1, id_ex_bubble=0, if_id_flush=0, busy=0, done=0. fwd_a and fwd_b follow their combinational rules.
- Load-use detect (lu): ex_mem_read & ex_rd_addr!=0 & (ex_rd_addr==id_rs_addr | (id_uses_rt & ex_rd_addr==id_rt_addr)).
- IDLE: hazard=1. On valid=1, go to RUN and clear stall_count.
- RUN, priority order:
  - branch_taken: assert if_id_flush this cycle, go to FLUSH, load the flush counter with FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN. Branch beats lu.
  - opr_finished: go to DRAIN, counter=DRAIN_CYCLES-1.
  - lu: assert hazard=1 and id_ex_bubble=1 in the same cycle (Mealy), increment stall_count, go to STALL.
  - Otherwise all stall outputs are 0.
- STALL: exactly one cycle, hazard=0, bubble=0, return to RUN. A second lu in the following RUN cycle produces another stall. Back-to-back stalls are legal.
- FLUSH: if_id_flush=1 and hazard=0. Decrement the counter; go to RUN when it reaches 0. branch_taken seen in FLUSH reloads the counter.
- opr_finished seen in STALL or FLUSH sets pend_stop. On the return to RUN, go directly to DRAIN that cycle; pend_stop takes priority over lu and branch.
- DRAIN: hazard=1, id_ex_bubble=1, if_id_flush=0, so no new instructions enter. Decrement the counter; at 0 go to DONE. branch_taken and lu are ignored.
- DONE: done=1 for one cycle, hazard=1, then IDLE.
- busy=1 in every state except IDLE.
- stall_count saturates at 16'hFFFF and holds its value in IDLE.
- Forwarding (combinational, valid in all states):
  - fwd_a=10 if memst_reg_write & memst_rd_addr!=0 & memst_rd_addr==id_rs_addr.
  - Else fwd_a=01 if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==id_rs_addr.
  - Else fwd_a=00.
  - fwd_b uses the same rule against id_rt_addr. EX/MEM beats MEM/WB.
- Register 0 never triggers a stall or forwarding.

Test Plan:
- reset 3 cycles then release, valid=0 -> hazard=1, busy=0, done=0, stall_count=0. Pulse valid -> next cycle busy=1, hazard=0.
- RUN, ex_mem_read=1, ex_rd_addr=5, id_rs_addr=5 -> same cycle hazard=1 and id_ex_bubble=1, stall_count=1, next cycle both outputs 0. Repeat with ex_rd_addr=0 -> no stall.
- RUN, branch_taken=1 together with lu -> if_id_flush=1 for 2 cycles, hazard=0, stall_count unchanged.
- memst_rd_addr=wb_rd_addr=7, both write enables=1, id_rs_addr=7, id_rt_addr=7 -> fwd_a=10, fwd_b=10. Drop memst_reg_write -> fwd_a=01, fwd_b=01.
- opr_finished during FLUSH -> after flush ends, 4 DRAIN cycles with hazard=1 and bubble=1, then done=1 for one cycle, then IDLE.
- reset asserted mid-DRAIN -> next cycle IDLE, hazard=1, done never pulses, stall_count=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Interface for the pipeline sequencing controller: run/drain handshake, hazard
// inputs from the ID/EX/MEM/WB stages, and stall/flush/forwarding outputs.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ADDR_LINE_REG = 5
);
  logic                     valid;
  logic                     opr_finished;
  logic [ADDR_LINE_REG-1:0] id_rs_addr;
  logic [ADDR_LINE_REG-1:0] id_rt_addr;
  logic                     id_uses_rt;
  logic [ADDR_LINE_REG-1:0] ex_rd_addr;
  logic                     ex_mem_read;
  logic [ADDR_LINE_REG-1:0] memst_rd_addr;
  logic                     memst_reg_write;
  logic [ADDR_LINE_REG-1:0] wb_rd_addr;
  logic                     wb_reg_write;
  logic                     branch_taken;
  logic                     hazard;
  logic                     id_ex_bubble;
  logic                     if_id_flush;
  logic [1:0]               fwd_a;
  logic [1:0]               fwd_b;
  logic                     busy;
  logic                     done;
  logic [15:0]              stall_count;

  modport master (
    output valid, opr_finished, id_rs_addr, id_rt_addr, id_uses_rt,
           ex_rd_addr, ex_mem_read, memst_rd_addr, memst_reg_write,
           wb_rd_addr, wb_reg_write, branch_taken,
    input  hazard, id_ex_bubble, if_id_flush, fwd_a, fwd_b, busy, done,
           stall_count
  );

  modport slave (
    input  valid, opr_finished, id_rs_addr, id_rt_addr, id_uses_rt,
           ex_rd_addr, ex_mem_read, memst_rd_addr, memst_reg_write,
           wb_rd_addr, wb_reg_write, branch_taken,
    output hazard, id_ex_bubble, if_id_flush, fwd_a, fwd_b, busy, done,
           stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: run/drain lifecycle, load-use stalls,
// branch flush of IF/ID and EX operand forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned ADDR_LINE_REG = 5,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STALL, S_FLUSH, S_DRAIN, S_DONE
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [ADDR_LINE_REG-1:0] rs, rt, ex_rd, mem_rd, wb_rd;
  logic       lu, stop_req;
  logic       hazard, bubble, flush, done;
  logic [1:0] fwd_a, fwd_b;

  assign rs     = bus.id_rs_addr;
  assign rt     = bus.id_rt_addr;
  assign ex_rd  = bus.ex_rd_addr;
  assign mem_rd = bus.memst_rd_addr;
  assign wb_rd  = bus.wb_rd_addr;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_LINE_REG-1:0] src);
    if (bus.memst_reg_write && mem_rd != '0 && mem_rd == src) return 2'b10;
    if (bus.wb_reg_write && wb_rd != '0 && wb_rd == src)      return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    lu = bus.ex_mem_read && ex_rd != '0 &&
         (ex_rd == rs || (bus.id_uses_rt && ex_rd == rt));
    // A stop seen in STALL/FLUSH is honoured when that state would return to RUN.
    stop_req    = pend_q | bus.opr_finished;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    stall_cnt_d = stall_cnt_q;
    hazard      = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    done        = 1'b0;
    fwd_a       = fwd_sel(rs);
    fwd_b       = fwd_sel(rt);

    case (state_q)
      S_IDLE: begin
        hazard = 1'b1;
        if (bus.valid) begin
          state_d     = S_RUN;
          stall_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (bus.branch_taken) begin
          flush = 1'b1;
          cnt_d = FLUSH_LOAD;
          if (FLUSH_CYCLES > 1) state_d = S_FLUSH;
        end else if (bus.opr_finished) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (lu) begin
          hazard  = 1'b1;
          bubble  = 1'b1;
          state_d = S_STALL;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
      S_STALL: begin
        if (stop_req) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (bus.branch_taken) begin
          cnt_d  = FLUSH_LOAD;
          pend_d = stop_req;
        end else if (cnt_q == 4'd1) begin
          if (stop_req) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          pend_d = stop_req;
        end
      end
      S_DRAIN: begin
        hazard = 1'b1;
        bubble = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        hazard  = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.hazard       = hazard;
  assign bus.id_ex_bubble = bubble;
  assign bus.if_id_flush  = flush;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done;
  assign bus.stall_count  = stall_cnt_q;

endmodule
